// File: rtl/mcu_sequencer.sv
// ============================================================================
// Module   : mcu_sequencer
// Purpose  : Fetch/decode/execute sequencer with memory-ready wait states,
//            timeout bus error, HALT/restart and optional retire counter
//            (enabled by the SEQ_RETIRE_CNT_EN macro).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcu_sequencer #(
    parameter int OP_W     = 3,
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = $clog2(MAX_WAIT + 2)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    input  logic            mem_rdy,
    input  logic            start,
    output logic            ld_acc,
    output logic            ld_mdr,
    output logic            ld_ir,
    output logic            dout_en,
    output logic            ld_pc,
    output logic            inc,
    output logic            sel,
    output logic            rd,
    output logic            wr,
    output logic            halted,
    output logic            bus_err,
    output logic [2:0]      state_o
`ifdef SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0]     retire_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC1  = 3'b010,
        S_EXEC2  = 3'b011,
        S_HALT   = 3'b100
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic                bus_err_q, bus_err_d;

    logic                w_alu_op;
    logic                w_mem_op;
    logic                w_access;
    logic                w_timeout;

    // Opcodes 2..5 read an operand; 6 writes one. Wider opcodes >= 8 never match.
    assign w_alu_op  = (op >= OP_W'(2)) && (op <= OP_W'(5));
    assign w_mem_op  = w_alu_op || (op == OP_W'(6));
    assign w_access  = (state_q == S_FETCH) || ((state_q == S_EXEC1) && w_mem_op);
    assign w_timeout = (MAX_WAIT > 0) && w_access && !mem_rdy
                       && (cnt_q == WAIT_W'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_HALT;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bus_err_d = bus_err_q;
        ld_acc    = 1'b0;
        ld_mdr    = 1'b0;
        ld_ir     = 1'b0;
        dout_en   = 1'b0;
        ld_pc     = 1'b0;
        inc       = 1'b0;
        sel       = 1'b0;
        rd        = 1'b0;
        wr        = 1'b0;
        case (state_q)
            S_HALT: begin
                if (start) begin
                    state_d   = S_FETCH;
                    bus_err_d = 1'b0;
                end
            end
            S_FETCH: begin
                rd = 1'b1;
                if (mem_rdy) begin
                    ld_ir   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC1;
            S_EXEC1: begin
                if (op == OP_W'(0)) begin
                    sel     = 1'b1;
                    state_d = S_HALT;
                end else if (op == OP_W'(1)) begin
                    sel     = 1'b1;
                    inc     = 1'b1;
                    state_d = S_EXEC2;
                end else if (w_alu_op) begin
                    sel = 1'b1;
                    rd  = 1'b1;
                    if (mem_rdy) begin
                        ld_mdr  = 1'b1;
                        inc     = 1'b1;
                        state_d = S_EXEC2;
                    end
                end else if (op == OP_W'(6)) begin
                    sel     = 1'b1;
                    wr      = 1'b1;
                    dout_en = 1'b1;
                    if (mem_rdy) begin
                        inc     = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (op == OP_W'(7)) begin
                    sel     = 1'b1;
                    ld_pc   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC2: begin
                if (op == OP_W'(1)) begin
                    inc = zero;
                end
                ld_acc  = w_alu_op;
                state_d = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
        // A stalled access cannot reach mem_rdy-gated strobes, so only the exit matters.
        if (w_timeout) begin
            state_d   = S_HALT;
            bus_err_d = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (w_access && !mem_rdy) begin
            cnt_d = cnt_q + WAIT_W'(1);
        end
    end

    assign halted  = (state_q == S_HALT);
    assign bus_err = bus_err_q;
    assign state_o = state_q;

`ifdef SEQ_RETIRE_CNT_EN
    logic [15:0] retire_q, retire_d;

    always_comb begin
        retire_d = retire_q;
        if ((state_d == S_FETCH) && ((state_q == S_EXEC1) || (state_q == S_EXEC2))) begin
            retire_d = retire_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign retire_cnt = retire_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mcu_sequencer.sv
// ============================================================================
// Module   : tb_mcu_sequencer
// Purpose  : Directed plus randomized bench for mcu_sequencer against a
//            cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcu_sequencer;

    localparam int OP_W     = 4;
    localparam int MAX_WAIT = 4;

    localparam logic [8:0] LD_ACC = 9'h100, LD_MDR = 9'h080, LD_IR = 9'h040,
                           DOUT   = 9'h020, LD_PC  = 9'h010, INC   = 9'h008,
                           SEL    = 9'h004, RD     = 9'h002, WR    = 9'h001;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [OP_W-1:0] op = '0;
    logic            zero = 1'b0, mem_rdy = 1'b0, start = 1'b0;
    logic            ld_acc, ld_mdr, ld_ir, dout_en, ld_pc, inc, sel, rd, wr;
    logic            halted, bus_err;
    logic [2:0]      state_o;
`ifdef SEQ_RETIRE_CNT_EN
    logic [15:0]     retire_cnt;
`endif
    logic [8:0]      strb;

    int checks = 0;
    int failures = 0;

    mcu_sequencer #(.OP_W(OP_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_rdy(mem_rdy), .start(start),
        .ld_acc(ld_acc), .ld_mdr(ld_mdr), .ld_ir(ld_ir), .dout_en(dout_en),
        .ld_pc(ld_pc), .inc(inc), .sel(sel), .rd(rd), .wr(wr),
        .halted(halted), .bus_err(bus_err), .state_o(state_o)
`ifdef SEQ_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );

    always #5 clk = ~clk;
    assign strb = {ld_acc, ld_mdr, ld_ir, dout_en, ld_pc, inc, sel, rd, wr};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model phases: 0 HALT, 1 FETCH, 2 DECODE, 3 EXEC1, 4 EXEC2.
    logic [2:0] ph_enc [5] = '{3'b100, 3'b000, 3'b001, 3'b010, 3'b011};
    int  m_ph = 0, m_stall = 0, m_ret = 0;
    bit  m_err = 0, m_valid = 0;

    function automatic void model(input int ph, input logic [OP_W-1:0] o, input logic z,
                                  input logic rdy, input logic st, input int stall,
                                  output logic [8:0] s, output int nph, output bit tout);
        bit ldcls, acc;
        ldcls = (o >= 2) && (o <= 5);
        acc   = (ph == 1) || (ph == 3 && o >= 2 && o <= 6);
        tout  = acc && !rdy && (stall == MAX_WAIT);
        s = '0;
        nph = ph;
        case (ph)
            0: if (st) nph = 1;
            1: begin s = RD; if (rdy) begin s |= LD_IR; nph = 2; end end
            2: nph = 3;
            3: begin
                if (o == 0) begin s = SEL; nph = 0; end
                else if (o == 1) begin s = SEL | INC; nph = 4; end
                else if (ldcls) begin s = SEL | RD; if (rdy) begin s |= LD_MDR | INC; nph = 4; end end
                else if (o == 6) begin s = SEL | WR | DOUT; if (rdy) begin s |= INC; nph = 1; end end
                else if (o == 7) begin s = SEL | LD_PC; nph = 1; end
                else nph = 1;
            end
            default: begin
                if (o == 1 && z) s = INC;
                if (ldcls) s = LD_ACC;
                nph = 1;
            end
        endcase
        if (tout) nph = 0;
    endfunction

    always @(negedge clk) begin
        logic [8:0] es;
        int np;
        bit to;
        if (m_valid) begin
            model(m_ph, op, zero, mem_rdy, start, m_stall, es, np, to);
            chk("m_strobes", {23'd0, strb}, {23'd0, es});
            chk("m_state", {29'd0, state_o}, {29'd0, ph_enc[m_ph]});
            chk("m_flags", {30'd0, halted, bus_err}, {30'd0, (m_ph == 0), m_err});
`ifdef SEQ_RETIRE_CNT_EN
            chk("m_retire", {16'd0, retire_cnt}, m_ret & 32'hFFFF);
`endif
        end
    end

    always @(posedge clk) begin
        logic [8:0] es;
        int np;
        bit to, acc;
        if (rst) begin
            m_ph = 0; m_stall = 0; m_err = 0; m_ret = 0; m_valid = 1;
        end else if (m_valid) begin
            model(m_ph, op, zero, mem_rdy, start, m_stall, es, np, to);
            acc = (m_ph == 1) || (m_ph == 3 && op >= 2 && op <= 6);
            if (to) m_err = 1;
            if (m_ph == 0 && start) m_err = 0;
            if (np == 1 && (m_ph == 3 || m_ph == 4)) m_ret = (m_ret + 1) & 16'hFFFF;
            m_stall = (np != m_ph) ? 0 : ((acc && !mem_rdy) ? m_stall + 1 : m_stall);
            m_ph = np;
        end
    end

    task automatic cyc(input logic [OP_W-1:0] o, input logic z, input logic r, input logic s);
        op = o; zero = z; mem_rdy = r; start = s;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit low;
        // Test 1: reset, start, ADD with zero-wait memory
        cyc(0, 0, 0, 0); adv(); rst = 0;
        cyc(2, 0, 1, 1); chk("t1_reset", {state_o, halted, bus_err, strb}, {3'b100, 1'b1, 1'b0, 9'h0}); adv();
        cyc(2, 0, 1, 0); chk("t1_fetch", {state_o, strb}, {3'b000, RD | LD_IR}); adv();
        cyc(2, 0, 1, 0); chk("t1_decode", {state_o, strb}, {3'b001, 9'h0}); adv();
        cyc(2, 0, 1, 0); chk("t1_exec1", {state_o, strb}, {3'b010, SEL | RD | LD_MDR | INC}); adv();
        cyc(2, 0, 1, 0); chk("t1_exec2", {state_o, strb}, {3'b011, LD_ACC}); adv();
        // Test 2: fetch with 3 stalls, then JUMP
        for (int i = 0; i < 3; i++) begin
            cyc(7, 0, 0, 0); chk("t2_stall", {state_o, strb, bus_err}, {3'b000, RD, 1'b0}); adv();
        end
        cyc(7, 0, 1, 0); chk("t2_done", {state_o, strb, bus_err}, {3'b000, RD | LD_IR, 1'b0}); adv();
        cyc(7, 0, 1, 0); adv();
        cyc(7, 0, 1, 0); chk("t5_jump", {state_o, strb}, {3'b010, SEL | LD_PC}); adv();
        // Test 3: fetch timeout
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0); chk("t3_stall", {state_o, strb, bus_err}, {3'b000, RD, 1'b0}); adv();
        end
        cyc(0, 0, 0, 0); chk("t3_timeout", {state_o, halted, bus_err, strb}, {3'b100, 1'b1, 1'b1, 9'h0}); adv();
        cyc(1, 1, 1, 1); chk("t3_hold", {state_o, bus_err}, {3'b100, 1'b1}); adv();
        cyc(1, 1, 1, 0); chk("t3_restart", {state_o, bus_err}, {3'b000, 1'b0}); adv();
        // Test 4: SKZ with zero=1 then zero=0
        cyc(1, 1, 1, 0); adv();
        cyc(1, 1, 1, 0); chk("t4_ex1_z1", {state_o, strb}, {3'b010, SEL | INC}); adv();
        cyc(1, 1, 1, 0); chk("t4_ex2_z1", {state_o, strb}, {3'b011, INC}); adv();
        cyc(1, 0, 1, 0); adv();
        cyc(1, 0, 1, 0); adv();
        cyc(1, 0, 1, 0); chk("t4_ex1_z0", {state_o, strb}, {3'b010, SEL | INC}); adv();
        cyc(1, 0, 1, 0); chk("t4_ex2_z0", {state_o, strb}, {3'b011, 9'h0}); adv();
        // Test 5: STORE with 2 stalls, then HALT opcode
        cyc(6, 0, 1, 0); adv();
        cyc(6, 0, 1, 0); adv();
        for (int i = 0; i < 2; i++) begin
            cyc(6, 0, 0, 0); chk("t5_st_stall", {state_o, strb}, {3'b010, SEL | WR | DOUT}); adv();
        end
        cyc(6, 0, 1, 0); chk("t5_st_done", {state_o, strb}, {3'b010, SEL | WR | DOUT | INC}); adv();
        cyc(0, 0, 1, 0); chk("t5_st_next", {28'd0, state_o}, {28'd0, 3'b000}); adv();
        cyc(0, 0, 1, 0); adv();
        cyc(0, 0, 1, 0); chk("t5_halt_ex1", {state_o, strb}, {3'b010, SEL}); adv();
        cyc(0, 0, 1, 0); chk("t5_halted", {state_o, halted}, {3'b100, 1'b1}); adv();
        // Test 6: retire count and reset during an EXEC1 load stall
        rst = 1; cyc(0, 0, 0, 0); adv(); rst = 0;
        cyc(7, 0, 1, 1); adv();
        for (int i = 0; i < 9; i++) begin
            cyc(7, 0, 1, 0); adv();
        end
        cyc(3, 0, 1, 0); chk("t6_fetch", {28'd0, state_o}, {28'd0, 3'b000});
`ifdef SEQ_RETIRE_CNT_EN
        chk("t6_retire3", {16'd0, retire_cnt}, 32'd3);
`endif
        adv();
        cyc(3, 0, 1, 0); adv();
        cyc(3, 0, 0, 0); chk("t6_ld_stall", {state_o, strb}, {3'b010, SEL | RD});
        rst = 1; adv(); rst = 0;
        cyc(3, 0, 0, 0); chk("t6_after_rst", {state_o, halted, strb}, {3'b100, 1'b1, 9'h0});
`ifdef SEQ_RETIRE_CNT_EN
        chk("t6_retire0", {16'd0, retire_cnt}, 32'd0);
`endif
        adv();
        // Randomized phase, with bursts of slow memory to provoke timeouts
        low = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) low = ~low;
            rst = ($urandom_range(0, 299) == 0);
            cyc(OP_W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) < (low ? 1 : 7)), ($urandom_range(0, 2) == 0));
            adv();
        end
        rst = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mcu_sequencer.md
Name: mcu_sequencer

Overview:
Registered instruction sequencer for the 8-bit CISC MCU. It holds the fetch/decode/execute state register internally and drives the datapath strobes. It adds a memory-ready handshake with bounded wait states, a true HALT state with a restart input, a sticky bus-error flag, and a parametrised opcode width. It sits between the IR opcode field, the ACC zero flag, the memory bus and the datapath load/mux controls.

Parameters:
OP_W, 3, opcode width; must be >= 3; opcodes >= 8 are NOPs.
MAX_WAIT, 15, maximum stall cycles per memory access; 0 disables the timeout.
WAIT_W, $clog2(MAX_WAIT+2), width of the internal wait counter (derived; do not override).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, synchronous, active-high.
op  input  OP_W  opcode from IR.
zero  input  1  ACC == 0 flag.
mem_rdy  input  1  memory completes the current rd/wr this cycle.
start  input  1  leave HALT; sampled only in HALT.
ld_acc, ld_mdr, ld_ir, dout_en, ld_pc, inc, sel, rd, wr  output  1 each  datapath/bus strobes.
halted  output  1  state == HALT.
bus_err  output  1  sticky memory timeout flag.
state_o  output  3  current state encoding.

Behaviour:
- States (state_o encoding): HALT=3'b100, FETCH=3'b000, DECODE=3'b001, EXEC1=3'b010, EXEC2=3'b011.
- Reset: state=HALT, wait counter=0, bus_err=0. All strobes are 0 and halted=1 in the following cycle. rst overrides every other input, including mid-access.
- Strobes are combinational from (state, op, zero, mem_rdy). Any strobe not listed below is 0.
- HALT:
  - start=1 -> FETCH, and bus_err clears.
  - Otherwise remain in HALT.
- FETCH:
  - rd=1 held.
  - ld_ir=1 only in the cycle mem_rdy=1, then -> DECODE.
  - Otherwise stall.
- DECODE: no strobes; -> EXEC1.
- EXEC1 by op:
  - 0 HALT: sel=1; -> HALT.
  - 1 SKZ: sel=1, inc=1; -> EXEC2.
  - 2 ADD / 3 AND / 4 XOR / 5 LOAD: sel=1, rd=1 held. ld_mdr=1 and inc=1 only when mem_rdy=1, then -> EXEC2.
  - 6 STORE: sel=1, wr=1, dout_en=1 held. inc=1 only when mem_rdy=1, then -> FETCH.
  - 7 JUMP: sel=1, ld_pc=1; -> FETCH.
  - >=8: no strobes; -> FETCH.
- EXEC2 by op:
  - SKZ: inc=zero.
  - ADD/AND/XOR/LOAD: ld_acc=1.
  - Other opcodes: no strobes.
  - Always -> FETCH.
- Wait handling:
  - The wait counter clears on entry to any memory-access state.
  - It increments on each cycle of that state with mem_rdy=0.
  - Timeout fires when mem_rdy=0 in a cycle where counter == MAX_WAIT (i.e. the (MAX_WAIT+1)-th consecutive stall cycle), with MAX_WAIT > 0.
  - On timeout: no ld_* or inc that cycle; bus_err is set (visible next cycle); -> HALT.
  - If mem_rdy=1 in the same cycle the counter reaches MAX_WAIT, completion wins and there is no error.
- mem_rdy is ignored in non-access states. start is ignored outside HALT.
- Zero-wait memory (mem_rdy tied 1) gives a 4-cycle ALU op and a 3-cycle STORE/JUMP.

Optional Feature:
- Macro: SEQ_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt, 16 bits.
  - Increments by 1 on every transition into FETCH from EXEC1 or EXEC2; not on the HALT -> FETCH transition.
  - Wraps 16'hFFFF -> 0.
  - Cleared by rst only.
- Undefined: no port and no counter logic. All other behaviour is identical.

Test Plan:
1. Reset then start=1 for 1 cycle, mem_rdy=1, op=2 (ADD). Required state_o sequence: 100, 000, 001, 010, 011, 000. Strobes: ld_ir in FETCH; rd+ld_mdr+inc in EXEC1; ld_acc in EXEC2.
2. MAX_WAIT=4, op fetch with mem_rdy=0 for 3 cycles, then 1. FETCH lasts 4 cycles, rd=1 throughout, ld_ir=1 only in the 4th, bus_err stays 0.
3. MAX_WAIT=4, mem_rdy held 0 in FETCH. bus_err=1 and state_o=100 after the 5th FETCH cycle; start=1 clears bus_err and re-enters FETCH.
4. op=1 (SKZ) with zero=1, then zero=0. EXEC1 gives inc=1 in both runs; EXEC2 gives inc=1, then inc=0 respectively.
5. op=6 (STORE) with 2 stall cycles: wr=1 and dout_en=1 for 3 cycles, inc only in the last, next state 000. op=7 (JUMP): ld_pc=1 for one cycle, no rd/wr. op=0: enters HALT with halted=1.
6. rst asserted during an EXEC1 load stall. Next cycle state_o=100, all strobes 0. With SEQ_RETIRE_CNT_EN: after 3 completed instructions retire_cnt=3; after rst retire_cnt=0.
